// File: rtl/hamming_pkg.sv
// Shared [7,4] Hamming types and encode helpers used by the transmit encoder and the matching decoder.
package hamming_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] codeword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } enc_state_t;

  localparam logic [2:0] INJ_NONE = 3'd7;

  // Data occupies c[6:3]; c[2:0] are the parities the decoder recomputes for its syndrome.
  function automatic codeword_t hamming74_encode(input nibble_t d);
    codeword_t c;
    c[6] = d[3];
    c[5] = d[2];
    c[4] = d[1];
    c[3] = d[0];
    c[2] = d[3] ^ d[2] ^ d[0];
    c[1] = d[3] ^ d[1] ^ d[0];
    c[0] = d[2] ^ d[1] ^ d[0];
    return c;
  endfunction

  function automatic codeword_t hamming74_inj_mask(input logic en, input logic [2:0] pos);
    codeword_t m;
    m = '0;
    if (en && (pos != INJ_NONE)) begin
      m[pos] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_tx_encoder.sv
// Streaming [7,4] Hamming transmitter: one byte in, two registered codewords out (high nibble first),
// with optional single-bit error injection applied identically to both codewords of a byte.
module hamming_tx_encoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             inj_en,
  input  logic [2:0]       inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  output logic             out_last,
  output logic [CNT_W-1:0] cw_count
);

  enc_state_t       state_q, state_d;
  codeword_t        code_q, code_d;
  logic             last_q, last_d;
  nibble_t          lo_nib_q, lo_nib_d;
  logic             inj_en_q, inj_en_d;
  logic [2:0]       inj_pos_q, inj_pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  codeword_t new_hi_code;
  codeword_t lo_code;
  logic      out_fire;

  assign new_hi_code = hamming74_encode(nibble_t'(in_byte[7:4])) ^ hamming74_inj_mask(inj_en, inj_pos);
  assign lo_code     = hamming74_encode(lo_nib_q) ^ hamming74_inj_mask(inj_en_q, inj_pos_q);
  assign out_fire    = (state_q != IDLE) && out_ready;

  // in_ready is gated by rst_n so nothing is accepted during a reset edge.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = rst_n;
      LO:      in_ready = rst_n & out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    last_d    = last_q;
    lo_nib_d  = lo_nib_q;
    inj_en_d  = inj_en_q;
    inj_pos_d = inj_pos_q;
    cnt_d     = out_fire ? cnt_q + CNT_W'(1) : cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lo_nib_d  = nibble_t'(in_byte[3:0]);
          inj_en_d  = inj_en;
          inj_pos_d = inj_pos;
          code_d    = new_hi_code;
          last_d    = 1'b0;
          state_d   = HI;
        end
      end
      HI: begin
        if (out_ready) begin
          code_d  = lo_code;
          last_d  = 1'b1;
          state_d = LO;
        end
      end
      LO: begin
        if (out_ready && in_valid) begin
          lo_nib_d  = nibble_t'(in_byte[3:0]);
          inj_en_d  = inj_en;
          inj_pos_d = inj_pos;
          code_d    = new_hi_code;
          last_d    = 1'b0;
          state_d   = HI;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= '0;
      last_q    <= 1'b0;
      lo_nib_q  <= '0;
      inj_en_q  <= 1'b0;
      inj_pos_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      last_q    <= last_d;
      lo_nib_q  <= lo_nib_d;
      inj_en_q  <= inj_en_d;
      inj_pos_q <= inj_pos_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = (state_q != IDLE);
  assign out_code  = code_q;
  assign out_last  = last_q;
  assign cw_count  = cnt_q;

endmodule

// File: tb/tb_hamming_tx_encoder.sv
// Bench for hamming_tx_encoder: directed and random traffic checked against a queue-based
// reference of pending codewords; a second instance with a 4-bit counter exercises wrap-around.
module tb_hamming_tx_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        inj_en;
  logic [2:0]  inj_pos;
  logic        out_ready;

  logic        in_ready, out_valid, out_last;
  logic [6:0]  out_code;
  logic [15:0] cw_count;

  logic        in_ready4, out_valid4, out_last4;
  logic [6:0]  out_code4;
  logic [3:0]  cw_count4;

  int checks   = 0;
  int failures = 0;

  // Each entry is {last, codeword} for a codeword still owed to the sink.
  logic [7:0]  expQ[$];
  int unsigned modelCnt;
  bit          zeroCode;
  bit          synCheck;

  always #5 clk = ~clk;

  hamming_tx_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_last(out_last), .cw_count(cw_count)
  );

  hamming_tx_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_byte(in_byte),
    .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(out_valid4), .out_ready(out_ready),
    .out_code(out_code4), .out_last(out_last4), .cw_count(cw_count4)
  );

  function automatic logic [6:0] refEncode(input logic [3:0] d);
    logic p2, p1, p0;
    p2 = ^(d & 4'b1101);
    p1 = ^(d & 4'b1011);
    p0 = ^(d & 4'b0111);
    return {d, p2, p1, p0};
  endfunction

  function automatic logic [6:0] refMask(input logic en, input logic [2:0] pos);
    logic [6:0] m;
    m = 7'd0;
    if (en && pos < 3'd7) m = 7'd1 << pos;
    return m;
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {c[2] ^ c[6] ^ c[5] ^ c[3], c[1] ^ c[6] ^ c[4] ^ c[3], c[0] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] b, input logic ie,
                               input logic [2:0] ip, input logic orr, output bit accepted);
    bit inRdyExp;
    logic [6:0] m;
    @(posedge clk);
    #1;
    rst_n = rst; in_valid = v; in_byte = b; inj_en = ie; inj_pos = ip; out_ready = orr;
    @(negedge clk);
    inRdyExp = rst && (expQ.size() == 0 || (expQ.size() == 1 && orr));
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, inRdyExp});
    checkOutput("in_ready4", {31'd0, in_ready4}, {31'd0, inRdyExp});
    checkOutput("out_valid", {31'd0, out_valid}, (expQ.size() != 0) ? 32'd1 : 32'd0);
    if (expQ.size() != 0) begin
      checkOutput("out_code", {25'd0, out_code}, {25'd0, expQ[0][6:0]});
      checkOutput("out_last", {31'd0, out_last}, {31'd0, expQ[0][7]});
      checkOutput("out_code4", {25'd0, out_code4}, {25'd0, expQ[0][6:0]});
      if (synCheck) checkOutput("syndrome", {29'd0, syndrome(out_code)}, 32'd0);
    end else if (zeroCode) begin
      checkOutput("reset_code", {25'd0, out_code}, 32'd0);
      checkOutput("reset_last", {31'd0, out_last}, 32'd0);
    end
    checkOutput("cw_count", {16'd0, cw_count}, modelCnt & 32'hFFFF);
    checkOutput("cw_count4", {28'd0, cw_count4}, modelCnt & 32'hF);

    accepted = 1'b0;
    if (!rst) begin
      expQ.delete();
      modelCnt = 0;
      zeroCode = 1'b1;
    end else begin
      if (expQ.size() != 0 && orr) begin
        void'(expQ.pop_front());
        modelCnt++;
      end
      if (v && inRdyExp) begin
        m = refMask(ie, ip);
        expQ.push_back({1'b0, refEncode(b[7:4]) ^ m});
        expQ.push_back({1'b1, refEncode(b[3:0]) ^ m});
        zeroCode = 1'b0;
        accepted = 1'b1;
      end
    end
  endtask

  initial begin
    bit acc;
    int idx, guard, firstCyc, xfers;

    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; inj_en = 1'b0; inj_pos = 3'd7; out_ready = 1'b0;
    modelCnt = 0; zeroCode = 1'b1; synCheck = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then the B1 example
    applyStimulus(0, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(1, 1, 8'hB1, 0, 7, 1, acc);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_count", {16'd0, cw_count}, 32'd0);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("b1_hi", {25'd0, out_code}, 32'h5A);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("b1_lo", {25'd0, out_code}, 32'h0F);
    checkOutput("b1_lo_last", {31'd0, out_last}, 32'd1);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("b1_count", {16'd0, cw_count}, 32'd2);

    // Backpressure on 8F
    xfers = 0;
    applyStimulus(1, 1, 8'h8F, 0, 7, 0, acc);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 7, 0, acc);
      checkOutput("bp_hi_code", {25'd0, out_code}, 32'h46);
      checkOutput("bp_hi_rdy", {31'd0, in_ready}, 32'd0);
    end
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    if (out_valid && out_ready) xfers++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 7, 0, acc);
      if (out_valid && out_ready) xfers++;
      checkOutput("bp_lo_code", {25'd0, out_code}, 32'h7F);
      checkOutput("bp_lo_last", {31'd0, out_last}, 32'd1);
    end
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    if (out_valid && out_ready) xfers++;
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    if (out_valid && out_ready) xfers++;
    checkOutput("bp_xfers", xfers, 32'd2);

    // Injection at bit 2, then a follow-on byte with inj_pos = 7
    applyStimulus(1, 1, 8'h00, 1, 2, 1, acc);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("inj_hi", {25'd0, out_code}, 32'h04);
    applyStimulus(1, 1, 8'h00, 1, 7, 1, acc);
    checkOutput("inj_lo", {25'd0, out_code}, 32'h04);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("noinj_hi", {25'd0, out_code}, 32'h00);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("noinj_lo", {25'd0, out_code}, 32'h00);

    // Reset while holding in LO
    applyStimulus(1, 1, 8'h3C, 0, 7, 1, acc);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    applyStimulus(1, 0, 8'h00, 0, 7, 0, acc);
    applyStimulus(0, 0, 8'h00, 0, 7, 0, acc);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("rstlo_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstlo_count", {16'd0, cw_count}, 32'd0);
    checkOutput("rstlo_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("rstlo_stale", {31'd0, out_valid}, 32'd0);

    // All 256 bytes back-to-back after a fresh reset
    applyStimulus(0, 0, 8'h00, 0, 7, 1, acc);
    synCheck = 1'b1;
    idx = 0; guard = 0; firstCyc = 0;
    while (idx < 256 && guard < 2000) begin
      applyStimulus(1, 1, idx[7:0], 0, 7, 1, acc);
      if (acc) begin
        if (idx == 0) firstCyc = guard;
        idx++;
      end
      guard++;
    end
    checkOutput("exh_done", idx, 32'd256);
    checkOutput("exh_span", guard - 1 - firstCyc, 32'd510);
    repeat (3) applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("exh_count", {16'd0, cw_count}, 32'd512);
    synCheck = 1'b0;

    // Nine bytes on the 4-bit counter: 18 codewords wrap to 2
    applyStimulus(0, 0, 8'h00, 0, 7, 1, acc);
    idx = 0; guard = 0;
    while (idx < 9 && guard < 100) begin
      applyStimulus(1, 1, 8'($urandom), 0, 7, 1, acc);
      if (acc) idx++;
      guard++;
    end
    repeat (3) applyStimulus(1, 0, 8'h00, 0, 7, 1, acc);
    checkOutput("wrap_cnt4", {28'd0, cw_count4}, 32'd2);
    checkOutput("wrap_cnt16", {16'd0, cw_count}, 32'd18);

    // Random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom), 8'($urandom), 1'($urandom),
                    3'($urandom), ($urandom_range(0, 9) < 7), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_tx_encoder.md
# hamming_tx_encoder

Streaming Hamming [7,4] transmitter. Accepts data bytes on a valid/ready input and emits two 7-bit codewords per byte, high nibble first, on a valid/ready output. Codeword bit layout and parity equations match the team's [7,4] decoder, so a clean codeword always produces syndrome 0 there. A per-byte single-bit error-injection control lets benches and link tests exercise decoder correction.

## Interface
Parameters:
- CNT_W, 16, width of the transferred-codeword counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  in_byte is valid
- in_ready  out  1  block accepts in_byte this cycle
- in_byte  in  8  data byte; [7:4] encoded first
- inj_en  in  1  inject a single-bit error into both codewords of this byte
- inj_pos  in  3  codeword bit index to flip (0..6); 7 = no flip
- out_valid  out  1  out_code holds a codeword
- out_ready  in  1  downstream accepts out_code
- out_code  out  7  codeword
- out_last  out  1  out_code is the low-nibble codeword of its byte
- cw_count  out  CNT_W  number of codewords transferred

## Operation
- Encoding of nibble d[3:0] to c[6:0]:
  - c[6]=d3, c[5]=d2, c[4]=d1, c[3]=d0
  - c[2]=d3^d2^d0, c[1]=d3^d1^d0, c[0]=d2^d1^d0
- Error injection:
  - inj_en and inj_pos are sampled with the byte.
  - If inj_en=1 and inj_pos<7, bit inj_pos is inverted in both codewords of that byte.
- FSM states: IDLE, HI, LO.
  - IDLE: in_ready=1. On in_valid: latch the low nibble and injection controls, load out_code=enc(hi), out_last=0, go to HI.
  - HI: out_valid=1, in_ready=0. On out_ready: load out_code=enc(lo), out_last=1, go to LO.
  - LO: out_valid=1, in_ready=out_ready (combinational).
    - out_ready and in_valid: load the new byte's high codeword, go to HI.
    - out_ready only: go to IDLE.
    - Otherwise hold.
- cw_count increments by 1 on every out_valid && out_ready cycle and wraps modulo 2^CNT_W.
- out_code, out_last and the latched nibble stay stable while out_valid=1 && out_ready=0.
- inj_en and inj_pos are ignored when no transfer occurs.

## Timing
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, out_valid=0, out_code=0, out_last=0, cw_count=0, latched nibble/injection cleared.
  - in_ready=0 while rst_n=0.
- Reset mid-byte drops any pending codeword. The first cycle after reset is IDLE with in_ready=1.
- Latency: a byte accepted at edge N gives its high codeword valid after N. The low codeword follows on the cycle after the high codeword is accepted.
- Throughput: one codeword per cycle with out_ready held high, which is one byte per 2 cycles with no bubble.
- out_valid never falls without a completed transfer, except on reset.
- There is no combinational path from in_valid to out_* outputs. in_ready depends combinationally on out_ready only in state LO.

## Structure
- Package hamming_pkg:
  - nibble_t (logic [3:0]), codeword_t (logic [6:0])
  - enc_state_t enum {IDLE, HI, LO}
  - function hamming74_encode(nibble_t) returning codeword_t
  - constant INJ_NONE = 3'd7
- The decoder should import the same package for shared types.
- No sub-module. The encoder is the package function, and the FSM, output register and counter live in this module.

## Test plan
- After reset: out_valid=0, out_code=0, cw_count=0. Then in_byte=8'hB1 with out_ready=1 → out_code 7'h5A (out_last=0), then 7'h0F (out_last=1), cw_count=2.
- Exhaustive nibbles: bytes 8'h00..8'hFF back-to-back with out_ready=1 → each codeword passes the decoder syndrome equations with result 0. Bytes accepted every 2 cycles, no bubbles, cw_count=512.
- Backpressure: in_byte=8'h8F, out_ready low 5 cycles in HI, then 3 cycles in LO → out_code held at 7'h46, then 7'h7F. in_ready=0 throughout HI. Exactly 2 transfers.
- Injection: in_byte=8'h00, inj_en=1, inj_pos=2 → codewords 7'h04, 7'h04. Then inj_pos=7 → 7'h00, 7'h00.
- Counter wrap with CNT_W=4: 9 bytes → cw_count sequence wraps 15→0→1→2.
- Reset while in LO with out_ready=0 → next cycle out_valid=0, cw_count=0, in_ready=1, and no stale codeword is emitted.
